// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-3 responder for a 16-bit address+data frame in front of a 16 x 8 register file.
// Latency: SYNC_STAGES+1 i_ck cycles from any pin edge to the sample, shift, MISO update or commit pulse.
// Backpressure: none; the SPI master paces the link, and the fabric read port always answers in one cycle.
module spi_slave_regs #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic       i_ck,
  input  logic       i_rstn,
  input  logic       i_sclk,
  input  logic       i_csn,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_wr_stb,
  output logic [3:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_err,
  output logic       o_busy
);

  // Frame phases; the bit counter disambiguates positions inside each phase.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] CNT_ADDR_LAST = 5'd7;
  localparam logic [4:0] CNT_DATA_LAST = 5'd15;
  localparam logic [4:0] CNT_FULL      = 5'd16;
  localparam logic [4:0] CNT_SAT       = 5'd17;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   csn_d;
  logic                   sclk_s;
  logic                   csn_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   csn_rise;
  logic                   csn_fall;

  // prime fills with ones once the synchronizers hold real pin samples;
  // armed then waits for CSN to be seen high so a CSN held low across reset is ignored.
  logic [SYNC_STAGES:0]   prime;
  logic                   armed;

  logic [1:0]             state;
  logic [4:0]             cnt;
  logic [6:0]             addr_sr;
  logic [7:0]             tx_sr;
  logic [7:0]             rx_sr;
  logic                   wr_flag;
  logic [3:0]             idx;
  logic [7:0]             regs [16];

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_rise  = csn_s & ~csn_d;
  assign csn_fall  = ~csn_s & csn_d;

  assign o_busy    = (state != ST_IDLE);
  assign o_miso_oe = (state != ST_IDLE);

  // Synchronizer chains and edge-detect history, reset to the idle bus levels.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      sclk_sync <= '1;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      csn_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], i_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;
    end
  end

  // Arm frame detection only after CSN has been observed high since reset.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      prime <= '0;
      armed <= 1'b0;
    end else begin
      prime <= {prime[SYNC_STAGES-1:0], 1'b1};
      if (prime[SYNC_STAGES] && csn_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame engine: shift address and data, drive MISO, commit or flag on CSN rise.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr_sr     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      wr_flag     <= 1'b0;
      idx         <= '0;
      o_miso      <= 1'b0;
      o_wr_stb    <= 1'b0;
      o_frame_err <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      o_wr_stb    <= 1'b0;
      o_frame_err <= 1'b0;
      if (csn_fall && armed) begin
        // A new select always restarts, even over a frame that never closed.
        state  <= ST_ADDR;
        cnt    <= '0;
        o_miso <= 1'b0;
      end else if (csn_rise && (state != ST_IDLE)) begin
        if (cnt == CNT_FULL) begin
          if (wr_flag) begin
            regs[idx]  <= rx_sr;
            o_wr_stb   <= 1'b1;
            o_wr_addr  <= idx;
            o_wr_data  <= rx_sr;
          end
        end else begin
          o_frame_err <= 1'b1;
        end
        state  <= ST_IDLE;
        cnt    <= '0;
        o_miso <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          if (cnt != CNT_SAT) begin
            cnt <= cnt + 5'd1;
          end
          case (state)
            ST_ADDR: begin
              addr_sr <= {addr_sr[5:0], mosi_s};
              if (cnt == CNT_ADDR_LAST) begin
                // Snapshot the register before any write of this frame: read-modify-write order.
                wr_flag <= addr_sr[6];
                idx     <= {addr_sr[2:0], mosi_s};
                tx_sr   <= regs[{addr_sr[2:0], mosi_s}];
                state   <= ST_DATA;
              end
            end
            ST_DATA: begin
              rx_sr <= {rx_sr[6:0], mosi_s};
              if (cnt == CNT_DATA_LAST) begin
                state <= ST_DONE;
              end
            end
            default: begin
              // ST_DONE: extra edges only advance the saturating counter.
            end
          endcase
        end else if (sclk_fall && (state == ST_DATA)) begin
          o_miso <= tx_sr[7];
          tx_sr  <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  // Fabric read port, one cycle of latency.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rd_data <= RESET_VAL;
    end else begin
      o_rd_data <= regs[i_rd_addr];
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: directed plus randomized frames against a register-file reference model.
// Latency: drives SCLK at 20 i_ck cycles per half period and watches commit pulses after CSN rise.
// Backpressure: not applicable; the bench acts as the SPI master.
module tb_spi_slave_regs;

  localparam int SYNC = 2;
  localparam int HALF = 20;

  logic       i_ck = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_sclk = 1'b1;
  logic       i_csn = 1'b1;
  logic       i_mosi = 1'b0;
  logic       o_miso;
  logic       o_miso_oe;
  logic [3:0] i_rd_addr = 4'd5;
  logic [7:0] o_rd_data;
  logic       o_wr_stb;
  logic [3:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_frame_err;
  logic       o_busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] model [16];

  spi_slave_regs #(.SYNC_STAGES(SYNC), .RESET_VAL(8'h00)) dut (
    .i_ck(i_ck), .i_rstn(i_rstn), .i_sclk(i_sclk), .i_csn(i_csn), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_wr_stb(o_wr_stb), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 i_ck = ~i_ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watch a bounded window after CSN rise for commit and error pulses.
  task automatic close_window(output int stb_n, output int stb_first, output int err_n);
    stb_n = 0; stb_first = 0; err_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_ck);
      if (o_wr_stb === 1'b1) begin
        stb_n++;
        if (stb_first == 0) stb_first = k;
      end
      if (o_frame_err === 1'b1) err_n++;
    end
  endtask

  // One SPI mode-3 transfer of nbits clocks; returns the data-byte MISO bits.
  task automatic spi_frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                           output logic [7:0] rx, output int early_hi, output int busy_lo,
                           output int stb_n, output int stb_first, output int err_n);
    logic [15:0] word;
    word = {a, d};
    rx = 8'h00; early_hi = 0; busy_lo = 0;
    i_csn = 1'b0;
    repeat (HALF) @(negedge i_ck);
    for (int i = 0; i < nbits; i++) begin
      i_sclk = 1'b0;
      i_mosi = (i < 16) ? word[15-i] : 1'b0;
      repeat (HALF) @(negedge i_ck);
      if (i < 8 && o_miso !== 1'b0) early_hi++;
      if (o_busy !== 1'b1 || o_miso_oe !== 1'b1) busy_lo++;
      if (i >= 8 && i < 16) rx = {rx[6:0], o_miso};
      i_sclk = 1'b1;
      repeat (HALF) @(negedge i_ck);
    end
    i_csn = 1'b1;
    i_mosi = 1'b0;
    close_window(stb_n, stb_first, err_n);
  endtask

  task automatic check_rd(input string tag, input logic [3:0] a);
    i_rd_addr = a;
    repeat (2) @(negedge i_ck);
    check(tag, o_rd_data, model[a]);
  endtask

  // Full or truncated frame scored against the model.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] d, input int nbits);
    logic [7:0] rx;
    int early_hi, busy_lo, stb_n, stb_first, err_n;
    logic [7:0] exp_rx;
    exp_rx = model[a[3:0]];
    spi_frame(a, d, nbits, rx, early_hi, busy_lo, stb_n, stb_first, err_n);
    if (nbits >= 16) check({tag, "_miso"}, rx, exp_rx);
    if (nbits >= 8) check({tag, "_miso_early"}, early_hi, 0);
    if (nbits >= 1) check({tag, "_busy"}, busy_lo, 0);
    if (nbits == 16) begin
      check({tag, "_err"}, err_n, 0);
      if (a[7]) begin
        model[a[3:0]] = d;
        check({tag, "_stb_n"}, stb_n, 1);
        check({tag, "_stb_lat"}, stb_first, SYNC + 1);
        check({tag, "_wr_addr"}, o_wr_addr, a[3:0]);
        check({tag, "_wr_data"}, o_wr_data, d);
      end else begin
        check({tag, "_stb_n"}, stb_n, 0);
      end
    end else begin
      check({tag, "_err_n"}, err_n, 1);
      check({tag, "_stb_n"}, stb_n, 0);
    end
    check_rd({tag, "_rd"}, a[3:0]);
  endtask

  initial begin
    logic [7:0] ra, rd;
    int len, sel;
    int stb_n, stb_first, err_n;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    // Reset state.
    repeat (3) @(negedge i_ck);
    check("rst_miso", o_miso, 0);
    check("rst_oe", o_miso_oe, 0);
    check("rst_busy", o_busy, 0);
    check("rst_stb", o_wr_stb, 0);
    check("rst_err", o_frame_err, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_rd_data", o_rd_data, 8'h00);
    i_rstn = 1'b1;
    repeat (10) @(negedge i_ck);
    check_rd("rst_rd5", 4'd5);

    // Directed frames.
    run_frame("wr83", 8'h83, 8'hA5, 16);
    run_frame("rd03", 8'h03, 8'h5A, 16);
    run_frame("b2b1", 8'h83, 8'h11, 16);
    run_frame("b2b2", 8'h83, 8'h22, 16);
    check("reg3_final", model[3], 8'h22);
    run_frame("short12", 8'h84, 8'h77, 12);
    run_frame("long17", 8'h84, 8'h66, 17);
    run_frame("after_err", 8'h84, 8'h3C, 16);

    // Reset pulse after 10 bits of a write frame.
    i_csn = 1'b0;
    repeat (HALF) @(negedge i_ck);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] w;
      w = 16'h87C3;
      i_sclk = 1'b0;
      i_mosi = w[15-i];
      repeat (HALF) @(negedge i_ck);
      i_sclk = 1'b1;
      repeat (HALF) @(negedge i_ck);
    end
    i_rstn = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_oe", o_miso_oe, 0);
    check("mid_rst_miso", o_miso, 0);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (3) @(negedge i_ck);
    i_rstn = 1'b1;
    repeat (10) @(negedge i_ck);
    check("held_csn_idle", o_busy, 0);
    i_csn = 1'b1;
    i_mosi = 1'b0;
    close_window(stb_n, stb_first, err_n);
    check("mid_rst_stb", stb_n, 0);
    check_rd("mid_rst_rd7", 4'd7);
    run_frame("post_rst", 8'h87, 8'h99, 16);

    // Randomized frames.
    for (int n = 0; n < 14; n++) begin
      ra = 8'($urandom);
      rd = 8'($urandom);
      sel = $urandom_range(0, 5);
      if (sel == 0) len = $urandom_range(0, 15);
      else if (sel == 1) len = 17;
      else len = 16;
      run_frame($sformatf("rnd%0d", n), ra, rd, len);
    end

    // Final sweep of the whole register file.
    for (int i = 0; i < 16; i++) check_rd($sformatf("sweep%0d", i), 4'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI responder that terminates the 16-bit address+data frame issued by the team's SPI master: one address/command byte followed by one data byte, MSB first, SCLK idling high. It owns a 16 x 8 register file. Each frame returns the addressed register's current value on MISO during the data byte, and optionally writes the received data byte into that register. It sits on the peripheral side of the link, and on-chip fabric reads the register file through a side port.

## Interface
- SYNC_STAGES, 2: synchronizer depth for i_sclk, i_csn and i_mosi (minimum 2).
- RESET_VAL, 8'h00: reset value of every register-file entry.
- i_ck  in  1  system clock; all logic on its rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_sclk  in  1  SPI clock from the master, asynchronous to i_ck, idles high.
- i_csn  in  1  chip select, active low, asynchronous.
- i_mosi  in  1  serial data from the master.
- o_miso  out  1  serial data to the master.
- o_miso_oe  out  1  output enable for the MISO pad; 1 while the synchronized CSN is low.
- i_rd_addr  in  4  fabric read address.
- o_rd_data  out  8  register file [i_rd_addr], registered, 1-cycle latency.
- o_wr_stb  out  1  one-cycle pulse when a frame commits a write.
- o_wr_addr  out  4  register index written; held until the next commit.
- o_wr_data  out  8  value written; held until the next commit.
- o_frame_err  out  1  one-cycle pulse when CSN rises on a frame that is not exactly 16 bits long.
- o_busy  out  1  1 while a frame is in progress (synchronized CSN low).

## Operation
- i_sclk, i_csn and i_mosi each pass through a SYNC_STAGES flop chain, plus one history flop used for edge detection.
- Protocol is CPOL=1, CPHA=1:
  - the master changes MOSI on the SCLK falling edge and samples MISO on the rising edge;
  - the slave samples MOSI on the synchronized rising edge and updates MISO on the synchronized falling edge.
- Address byte: bit 7 is W (1 = write); bits 3:0 are the register index; bits 6:4 are ignored.
- States:
  - IDLE: CSN high. Bit counter is 0, o_miso = 0, SCLK edges are ignored.
  - ADDR: the first 8 rising edges shift MOSI into the address shift register. On the 8th rising edge, latch W and the index, and load the TX shift register with regs[index].
  - DATA: on each of the next 8 falling edges, drive o_miso from TX[7] and then shift TX left. On each of the next 8 rising edges, shift MOSI into the RX shift register.
  - DONE: reached after the 16th rising edge. Further SCLK edges are counted as overflow; the data is ignored.
- Bit counter is 5 bits and saturates at 17, so overflow can be detected.
- Synchronized CSN rising edge:
  - Count == 16 and W = 1: regs[index] <= RX, o_wr_stb pulses, o_wr_addr and o_wr_data update.
  - Count == 16 and W = 0: no write, no pulse.
  - Count != 16 (including 0): no write, o_frame_err pulses.
  - In every case, return to IDLE, clear the counter and drive o_miso = 0.
- The data byte returned in a frame is the register value before that frame's write (read-modify-write semantics).
- The first MISO data bit is driven on the 9th falling edge; before that, o_miso is 0 while CSN is low.
- Synchronized CSN falling edge always restarts the counter, even if the previous frame never closed cleanly.

## Timing
- Reset values:
  - o_miso = 0, o_miso_oe = 0, o_busy = 0, o_wr_stb = 0, o_frame_err = 0.
  - o_wr_addr = 0, o_wr_data = 0, o_rd_data = RESET_VAL.
  - All registers = RESET_VAL; synchronizers reset to idle levels (SCLK = 1, CSN = 1, MOSI = 0).
- Input-to-action latency is SYNC_STAGES + 1 i_ck cycles from a pin edge to the sample, shift or MISO update.
- SCLK high and low times must each be at least SYNC_STAGES + 3 i_ck cycles. At 100 MHz and 2.5 MHz SCLK (20 cycles per half period), o_miso settles about 17 cycles before the master samples it.
- o_wr_stb and o_frame_err assert SYNC_STAGES + 1 cycles after the pin-level CSN rise, for exactly 1 cycle.
- o_rd_data reflects a write on the cycle after o_wr_stb (same-cycle read returns the old value).
- i_rstn assertion mid-frame: everything clears immediately and no write occurs. After release, the block waits for a fresh CSN falling edge; a CSN that is already low is treated as IDLE until it goes high.

## Test plan
- Reset -> all outputs at their reset values; i_rd_addr = 5 gives o_rd_data = 8'h00.
- Frame addr 8'h83, data 8'hA5 -> MISO returns 8'h00; o_wr_stb pulses once with o_wr_addr = 3, o_wr_data = 8'hA5; the fabric read of address 3 then returns 8'hA5.
- After that write, frame addr 8'h03, data 8'h5A -> MISO returns 8'hA5; no o_wr_stb; register 3 stays 8'hA5.
- Frame addr 8'h83, data 8'h11, then immediately addr 8'h83, data 8'h22 -> second frame's MISO returns 8'h11; register 3 ends at 8'h22.
- CSN raised after 12 bits, and separately after 17 bits -> o_frame_err pulses each time; no write; the next good frame works normally.
- i_rstn pulsed low after 10 bits of a write frame -> register unchanged, no o_wr_stb; a following complete frame is decoded correctly.
